// File: rtl/aes_dec_sched.sv
// Issue scheduler and output buffer for the pipelined AES-128 decryptor.
// Optional statistics counters are enabled by defining AESD_STATS_EN.
module aes_dec_sched #(
    parameter int LATENCY    = 59,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [127:0]     key_in,
    output logic             key_ready,
    input  logic             s_valid,
    input  logic [127:0]     s_data,
    output logic             s_ready,
    output logic [127:0]     pipe_ct,
    output logic [127:0]     pipe_key10,
    input  logic [127:0]     pipe_pt,
    output logic             m_valid,
    output logic [127:0]     m_data,
    output logic [TAG_W-1:0] m_tag,
`ifdef AESD_STATS_EN
    output logic [31:0]      stat_in,
    output logic [31:0]      stat_out,
`endif
    input  logic             m_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        NOKEY,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   credit_used;
    logic [TAG_W-1:0] tag_cnt;

    logic [LATENCY:0]             vld_sr;
    logic [LATENCY:0][TAG_W-1:0]  tag_sr;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [127:0]     pt_mem  [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];

    logic issue;
    logic key_hs;
    logic capture;
    logic pop;

    assign issue   = s_valid && s_ready;
    assign key_hs  = key_valid && key_ready;
    assign capture = vld_sr[LATENCY];
    assign pop     = m_valid && m_ready;

    // Every block issued and not yet popped holds one credit.
    assign credit_used = (CNT_W + 1)'(inflight) + (CNT_W + 1)'(fifo_cnt);

    // ------------------------------------------------------------------
    // Key / issue sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NOKEY;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a latch behind.
    always_comb begin
        state_nx  = state;
        key_ready = 1'b0;
        s_ready   = 1'b0;
        case (state)
            NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) state_nx = RUN;
            end
            RUN: begin
                s_ready = (credit_used < DEPTH_C);
                if (key_valid) state_nx = DRAIN;
            end
            DRAIN: begin
                key_ready = (inflight == '0);
                if (key_valid && inflight == '0) state_nx = RUN;
            end
            default: state_nx = NOKEY;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_ct    <= '0;
            pipe_key10 <= '0;
            tag_cnt    <= '0;
        end else begin
            pipe_ct <= issue ? s_data : '0;
            if (key_hs) pipe_key10 <= key_in;
            if (issue)  tag_cnt    <= tag_cnt + TAG_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking: a block issued at edge E reaches the top bit
    // just before edge E+LATENCY+1, which is when its plaintext is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-1:0], issue};
        end
    end

    // NOTE: tag and FIFO storage are left unreset; the valid bits and the
    // FIFO count decide what is ever observed, so reset only touches those.
    always_ff @(posedge clk) begin
        tag_sr <= {tag_sr[LATENCY-1:0], tag_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO, first-word-fall-through
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            pt_mem[wr_ptr]  <= pipe_pt;
            tag_mem[wr_ptr] <= tag_sr[LATENCY];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({capture, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign m_valid = (fifo_cnt != '0);
    assign m_data  = m_valid ? pt_mem[rd_ptr]  : '0;
    assign m_tag   = m_valid ? tag_mem[rd_ptr] : '0;

`ifdef AESD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_in  <= '0;
            stat_out <= '0;
        end else begin
            if (issue) stat_in  <= stat_in + 32'd1;
            if (pop)   stat_out <= stat_out + 32'd1;
        end
    end
`endif

    // Credit bookkeeping must keep the FIFO from ever overflowing.
    a_credit: assert property (@(posedge clk) disable iff (rst)
        credit_used <= DEPTH_C);
    a_inflight: assert property (@(posedge clk) disable iff (rst)
        $countones(vld_sr) == int'(inflight));

endmodule
